// File: rtl/nrs_cmplx_conj_mult_pkg.sv
// Shared widths and constants for the NRS conjugate-multiply channel estimator.
// The pilot magnitude is 1/sqrt(2) in Q1.11.
package nrs_cmplx_conj_mult_pkg;

    localparam int WIDTH_R_I   = 16;
    localparam int CONST_WIDTH = 12;
    localparam int LONG_WIDTH  = WIDTH_R_I + CONST_WIDTH;
    localparam int DEPTH       = 4;
    localparam int ADDR_WIDTH  = 2;
    localparam int OUT_WIDTH   = WIDTH_R_I + 1;
    localparam int FRAC_SHIFT  = 11;

    localparam logic signed [CONST_WIDTH-1:0] NRS_MAG = 12'sd1448;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] re;
        logic signed [OUT_WIDTH-1:0] im;
    } est_t;

endpackage

// File: rtl/nrs_cmplx_conj_mult_if.sv
// Resource-element input and channel-estimate output bundle.
// The driver (master) supplies samples and addresses; the estimator (slave) returns results.
interface nrs_cmplx_conj_mult_if;
    import nrs_cmplx_conj_mult_pkg::*;

    logic                        en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic signed [WIDTH_R_I-1:0] rx_r;
    logic signed [WIDTH_R_I-1:0] rx_i;
    logic                        nrs_r;
    logic                        nrs_i;
    logic signed [OUT_WIDTH-1:0] real_part;
    logic signed [OUT_WIDTH-1:0] imag_part;
    logic signed [OUT_WIDTH-1:0] real_part_reg;
    logic signed [OUT_WIDTH-1:0] imag_part_reg;

    modport master (
        output en, wr_addr, rd_addr, rx_r, rx_i, nrs_r, nrs_i,
        input  real_part, imag_part, real_part_reg, imag_part_reg
    );

    modport slave (
        input  en, wr_addr, rd_addr, rx_r, rx_i, nrs_r, nrs_i,
        output real_part, imag_part, real_part_reg, imag_part_reg
    );

endinterface

// File: rtl/nrs_cmplx_conj_mult_gauss_mult3.sv
// Combinational rx * conj(pilot) using the Gauss three-multiplier form, then >>> FRAC_SHIFT.
// With x+jy = rx and p+jq = conj(pilot): re = p(x+y) - y(p+q), im = p(x+y) + x(q-p).
module cmplx_gauss_mult3
    import nrs_cmplx_conj_mult_pkg::*;
(
    input  logic signed [WIDTH_R_I-1:0] rx_r_i,
    input  logic signed [WIDTH_R_I-1:0] rx_i_i,
    input  logic                        nrs_r_i,
    input  logic                        nrs_i_i,
    output logic signed [OUT_WIDTH-1:0] re_o,
    output logic signed [OUT_WIDTH-1:0] im_o
);

    localparam logic signed [CONST_WIDTH:0] MAG_EXT = (CONST_WIDTH+1)'(NRS_MAG);

    logic signed [CONST_WIDTH:0]  p;
    logic signed [CONST_WIDTH:0]  q;
    logic signed [CONST_WIDTH:0]  q_minus_p;
    logic signed [CONST_WIDTH:0]  p_plus_q;
    logic signed [WIDTH_R_I:0]    sum_xy;
    logic signed [LONG_WIDTH-1:0] k1;
    logic signed [LONG_WIDTH-1:0] k2;
    logic signed [LONG_WIDTH-1:0] k3;
    logic signed [LONG_WIDTH-1:0] full_re;
    logic signed [LONG_WIDTH-1:0] full_im;

    // Every product and sum is bounded by 2*32768*1448, so LONG_WIDTH bits hold them exactly.
    always_comb begin
        p         = nrs_r_i ? -MAG_EXT : MAG_EXT;
        q         = nrs_i_i ? MAG_EXT : -MAG_EXT;
        q_minus_p = q - p;
        p_plus_q  = p + q;
        sum_xy    = (WIDTH_R_I+1)'(rx_r_i) + (WIDTH_R_I+1)'(rx_i_i);
        k1        = LONG_WIDTH'(sum_xy) * LONG_WIDTH'(p);
        k2        = LONG_WIDTH'(rx_r_i) * LONG_WIDTH'(q_minus_p);
        k3        = LONG_WIDTH'(rx_i_i) * LONG_WIDTH'(p_plus_q);
        full_re   = k1 - k3;
        full_im   = k1 + k2;
        re_o      = OUT_WIDTH'(full_re >>> FRAC_SHIFT);
        im_o      = OUT_WIDTH'(full_im >>> FRAC_SHIFT);
    end

endmodule

// File: rtl/nrs_cmplx_conj_mult.sv
// NRS channel-estimation front end: conjugate pilot multiply, registered copy of the
// latest estimate, and a 4-entry estimate buffer with combinational read.
module nrs_cmplx_conj_mult
    import nrs_cmplx_conj_mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    nrs_cmplx_conj_mult_if.slave    bus
);

    est_t est_d;
    est_t est_q;
    est_t buf_q [DEPTH];

    cmplx_gauss_mult3 u_mult (
        .rx_r_i  (bus.rx_r),
        .rx_i_i  (bus.rx_i),
        .nrs_r_i (bus.nrs_r),
        .nrs_i_i (bus.nrs_i),
        .re_o    (est_d.re),
        .im_o    (est_d.im)
    );

    // Reset wipes every stored estimate so stale channel data never reaches the averager.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            est_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (bus.en) begin
            est_q              <= est_d;
            buf_q[bus.wr_addr] <= est_d;
        end
    end

    assign bus.real_part_reg = est_q.re;
    assign bus.imag_part_reg = est_q.im;
    assign bus.real_part     = buf_q[bus.rd_addr].re;
    assign bus.imag_part     = buf_q[bus.rd_addr].im;

endmodule

// File: tb/tb_nrs_cmplx_conj_mult.sv
// Directed bench for nrs_cmplx_conj_mult: hand-computed corner vectors plus a sign sweep
// checked against a direct-formula model of rx * conj(pilot) >>> 11.
module tb_nrs_cmplx_conj_mult;
    import nrs_cmplx_conj_mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic signed [OUT_WIDTH-1:0] histRe [DEPTH];
    logic signed [OUT_WIDTH-1:0] histIm [DEPTH];
    logic signed [OUT_WIDTH-1:0] expRe;
    logic signed [OUT_WIDTH-1:0] expIm;

    nrs_cmplx_conj_mult_if bus ();

    nrs_cmplx_conj_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Direct textbook formula, deliberately not the three-multiplier form.
    function automatic logic signed [OUT_WIDTH-1:0] model(
        input logic signed [WIDTH_R_I-1:0] xr,
        input logic signed [WIDTH_R_I-1:0] xi,
        input logic nr,
        input logic ni,
        input bit wantIm
    );
        longint a;
        longint b;
        longint full;
        a = nr ? -64'sd1448 : 64'sd1448;
        b = ni ? -64'sd1448 : 64'sd1448;
        if (wantIm) full = longint'(xi) * a - longint'(xr) * b;
        else        full = longint'(xr) * a + longint'(xi) * b;
        return OUT_WIDTH'(full >>> 11);
    endfunction

    task automatic applyStimulus(
        input logic signed [WIDTH_R_I-1:0] xr,
        input logic signed [WIDTH_R_I-1:0] xi,
        input logic nr,
        input logic ni,
        input logic enable,
        input logic [ADDR_WIDTH-1:0] wa
    );
        bus.rx_r    = xr;
        bus.rx_i    = xi;
        bus.nrs_r   = nr;
        bus.nrs_i   = ni;
        bus.en      = enable;
        bus.wr_addr = wa;
    endtask

    task automatic checkOutput(
        input string tag,
        input logic signed [OUT_WIDTH-1:0] obs,
        input logic signed [OUT_WIDTH-1:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_re_reg"}, bus.real_part_reg, '0);
        checkOutput({tag, "_im_reg"}, bus.imag_part_reg, '0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = ADDR_WIDTH'(a);
            #1;
            checkOutput({tag, "_re_buf"}, bus.real_part, '0);
            checkOutput({tag, "_im_buf"}, bus.imag_part, '0);
        end
    endtask

    // One enabled write, then after the edge point the read port at the written slot.
    task automatic runStep(
        input logic signed [WIDTH_R_I-1:0] xr,
        input logic signed [WIDTH_R_I-1:0] xi,
        input logic nr,
        input logic ni,
        input logic [ADDR_WIDTH-1:0] wa
    );
        applyStimulus(xr, xi, nr, ni, 1'b1, wa);
        @(negedge clk);
        bus.rd_addr = wa;
        #1;
    endtask

    task automatic checkStep(
        input string tag,
        input logic signed [OUT_WIDTH-1:0] er,
        input logic signed [OUT_WIDTH-1:0] ei
    );
        checkOutput({tag, "_re_reg"}, bus.real_part_reg, er);
        checkOutput({tag, "_im_reg"}, bus.imag_part_reg, ei);
        checkOutput({tag, "_re_buf"}, bus.real_part, er);
        checkOutput({tag, "_im_buf"}, bus.imag_part, ei);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int v;
        logic [ADDR_WIDTH-1:0] slot;
        logic signed [WIDTH_R_I-1:0] xr;
        logic signed [WIDTH_R_I-1:0] xi;
        logic nr;
        logic ni;

        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, '0);
        bus.rd_addr = '0;

        repeat (4) begin
            @(negedge clk);
            applyStimulus(WIDTH_R_I'($urandom), WIDTH_R_I'($urandom), 1'($urandom),
                          1'($urandom), 1'b1, ADDR_WIDTH'($urandom));
        end
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        runStep(16'sd32767, 16'sd0, 1'b0, 1'b0, 2'd0);
        checkStep("floor", 17'sd23167, -17'sd23168);
        runStep(16'sd32767, 16'sd32767, 1'b0, 1'b0, 2'd1);
        checkStep("max_pos_00", 17'sd46334, 17'sd0);
        runStep(16'sd32767, 16'sd32767, 1'b1, 1'b1, 2'd2);
        checkStep("max_pos_11", -17'sd46335, 17'sd0);
        runStep(-16'sd32768, -16'sd32768, 1'b0, 1'b0, 2'd3);
        checkStep("max_neg_00", -17'sd46336, 17'sd0);
        runStep(-16'sd32768, -16'sd32768, 1'b0, 1'b1, 2'd0);
        checkStep("max_neg_01", 17'sd0, -17'sd46336);

        for (int idx = 0; idx < 8192; idx++) begin
            v = 65535 - 32 * (idx / 4);
            if (v == 32768 || v == 65536) v = 32767;
            xr   = WIDTH_R_I'(v);
            xi   = WIDTH_R_I'(65535 - v);
            nr   = 1'(idx >> 1);
            ni   = 1'(idx);
            slot = ADDR_WIDTH'(idx);
            if (idx == 4001) begin
                rst = 1'b0;
                #1;
                checkAllZero("mid_reset");
                @(negedge clk);
                rst = 1'b1;
            end
            expRe = model(xr, xi, nr, ni, 1'b0);
            expIm = model(xr, xi, nr, ni, 1'b1);
            runStep(xr, xi, nr, ni, slot);
            checkStep("sweep", expRe, expIm);
            histRe[slot] = expRe;
            histIm[slot] = expIm;
        end

        for (int k = 0; k < 3; k++) begin
            applyStimulus(WIDTH_R_I'(1000 * (k + 1)), WIDTH_R_I'(-777 * (k + 1)),
                          1'(k), 1'(k + 1), 1'b0, ADDR_WIDTH'(k));
            @(negedge clk);
        end
        #1;
        checkOutput("hold_re_reg", bus.real_part_reg, histRe[3]);
        checkOutput("hold_im_reg", bus.imag_part_reg, histIm[3]);
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = ADDR_WIDTH'(a);
            #1;
            checkOutput("hold_re_buf", bus.real_part, histRe[a]);
            checkOutput("hold_im_buf", bus.imag_part, histIm[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
